// File: rtl/pwm_pkg.sv
// Shared PWM constants and helpers, also used by the tone generator so both
// sides agree on the period length and the duty-to-threshold mapping.
`timescale 1ns/1ps
package pwm_pkg;

  localparam int unsigned PERIOD_WIDTH_NS_DEFAULT = 1000;
  localparam int unsigned SYS_FREQ_MHZ_DEFAULT    = 100;
  localparam int unsigned DUTY_WIDTH_DEFAULT      = 10;

  // Clock cycles in one PWM period.
  function automatic int unsigned cycles_per_period(input int unsigned period_ns,
                                                    input int unsigned sys_mhz);
    return (period_ns * sys_mhz) / 1000;
  endfunction

  // Number of high cycles per period for a duty word (floor, no rounding).
  function automatic int unsigned duty_to_threshold(input int unsigned duty,
                                                    input int unsigned cycles,
                                                    input int unsigned duty_width);
    return (duty * cycles) >> duty_width;
  endfunction

endpackage

// File: rtl/pwm_serializer_if.sv
// Duty word in, serial PWM bit out. The producer of the duty word is the
// master; the serializer is the slave.
`timescale 1ns/1ps
interface pwm_serializer_if
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_WIDTH = DUTY_WIDTH_DEFAULT
) ();

  logic [DUTY_WIDTH-1:0] duty_cycle;
  logic                  signal;

  modport master (output duty_cycle, input signal);
  modport slave  (input duty_cycle, output signal);

endinterface

// File: rtl/pwm_period_counter.sv
// Free-running 0..P-1 counter with a strobe on the last cycle of each period.
`timescale 1ns/1ps
module pwm_period_counter #(
  parameter  int unsigned P  = 100,
  localparam int unsigned CW = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clock,
  input  logic          reset,
  output logic [CW-1:0] count,
  output logic          period_end
);

  localparam logic [CW-1:0] LAST = CW'(P - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: wrap to zero after the last cycle of the period.
  always_comb begin
    period_end = (count_q == LAST);
    count_d    = period_end ? '0 : count_q + 1'b1;
  end

  // Count register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pwm_serializer.sv
// Duty word to fixed-frequency PWM. The duty word is sampled once per period
// so a change never produces a partial or merged pulse.
`timescale 1ns/1ps
module pwm_serializer
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH_NS = PERIOD_WIDTH_NS_DEFAULT,
  parameter int unsigned SYS_FREQ_MHZ    = SYS_FREQ_MHZ_DEFAULT,
  parameter int unsigned DUTY_WIDTH      = DUTY_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  pwm_serializer_if.slave  bus
);

  localparam int unsigned P  = cycles_per_period(PERIOD_WIDTH_NS, SYS_FREQ_MHZ);
  localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned TW = $clog2(P + 1);
  localparam int unsigned PW = DUTY_WIDTH + CW;

  if (P < 2) begin : g_period_check
    $fatal(1, "pwm_serializer: period must be at least 2 clock cycles");
  end

  logic [CW-1:0] count;
  logic          period_end;
  logic [PW-1:0] product;
  logic [TW-1:0] threshold_q, threshold_d;
  logic          signal_q, signal_d;

  pwm_period_counter #(.P(P)) u_counter (
    .clock      (clock),
    .reset      (reset),
    .count      (count),
    .period_end (period_end)
  );

  // Threshold reload at the period boundary and the output comparator.
  // NOTE: every value written here gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    product     = PW'(bus.duty_cycle) * PW'(P);
    threshold_d = threshold_q;
    if (period_end) threshold_d = TW'(product >> DUTY_WIDTH);
    signal_d    = (TW'(count) < threshold_q);
  end

  // Threshold and output registers; both clear at once on reset, which
  // forces the pin low mid-period and makes the first period all-low.
  // NOTE: every register is reset (there is no memory array here), so the
  // output never carries an unknown value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      threshold_q <= '0;
      signal_q    <= 1'b0;
    end else begin
      threshold_q <= threshold_d;
      signal_q    <= signal_d;
    end
  end

  assign bus.signal = signal_q;

endmodule

// File: tb/tb_pwm_serializer.sv
// Self-checking bench for pwm_serializer: directed scenarios plus random
// duty words, compared cycle by cycle against a period-level model.
`timescale 1ns/1ps
module tb_pwm_serializer;

  localparam int P  = 100;   // 1000 ns * 100 MHz
  localparam int DW = 10;
  localparam int FS = 1024;  // full scale of the duty word

  logic clock = 1'b0;
  logic reset;

  pwm_serializer_if #(.DUTY_WIDTH(DW)) bus ();

  pwm_serializer #(
    .PERIOD_WIDTH_NS (1000),
    .SYS_FREQ_MHZ    (100),
    .DUTY_WIDTH      (DW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int  n_assert = 0;
  int  n_fail   = 0;

  // Model: k edges since reset release; output period j = k / P is high for
  // its first thr cycles, where thr comes from the duty seen at the end of
  // period j-1 (zero for the very first period).
  int  k;
  int  thr;
  int  run_high;
  int  last_period_high;
  int  prev_d;
  logic prev_sig;
  time prev_rise = 0;
  time last_rise = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k        = 0;
    thr      = 0;
    run_high = 0;
    prev_sig = 1'b0;
  endtask

  // One clock: drive duty on the falling edge, sample 1 ns after the rise.
  task automatic tick(input int d);
    logic exp_sig;
    @(negedge clock);
    bus.duty_cycle = DW'(d);
    @(posedge clock);
    #1;
    exp_sig = ((k % P) < thr);
    check_bit($sformatf("signal k=%0d", k), bus.signal, exp_sig);
    if (bus.signal === 1'b1) run_high++;
    if (bus.signal === 1'b1 && prev_sig !== 1'b1) begin
      prev_rise = last_rise;
      last_rise = $time;
    end
    prev_sig = bus.signal;
    if ((k % P) == P - 1) begin
      thr              = (d * P) / FS;
      last_period_high = run_high;
      run_high         = 0;
    end
    k++;
  endtask

  // One full period at a steady duty; exp_high is the high count of the
  // period being played, which was set by the previous period's duty.
  task automatic run_period(input int d, input int exp_high, input string tag);
    repeat (P) tick(d);
    check_int(tag, last_period_high, exp_high);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 5 cycles
    reset          = 1'b1;
    bus.duty_cycle = '0;
    model_reset();
    repeat (5) @(posedge clock);
    #1;
    check_bit("reset signal low", bus.signal, 1'b0);
    #1;
    reset          = 1'b0;
    bus.duty_cycle = DW'(900);

    // 1: duty 900 -> first period low, then 87 high / 13 low
    run_period(900, 0, "t1 first period low");
    repeat (3) run_period(900, 87, "t1 duty900 high count");

    // 2: duty 100 -> 9 high, 1 MHz repetition
    run_period(100, 87, "t2 last 900 period");
    repeat (3) run_period(100, 9, "t2 duty100 high count");
    check_int("t2 rise spacing ns", int'(last_rise - prev_rise), 1000);

    // 3: duty 0 never high over 500 cycles; 1023 -> 99/1; 512 -> 50
    run_period(0, 9, "t3 last 100 period");
    repeat (5) run_period(0, 0, "t3 duty0 high count");
    run_period(1023, 0, "t3 last 0 period");
    repeat (2) run_period(1023, 99, "t3 duty1023 high count");
    run_period(512, 99, "t3 last 1023 period");
    run_period(512, 50, "t3 duty512 high count");

    // 4: mid-period duty changes only take effect at the boundary
    run_period(900, 50, "t4 last 512 period");
    repeat (40) tick(900);
    repeat (60) tick(100);
    check_int("t4 current period keeps 87", last_period_high, 87);
    repeat (40) tick(100);
    repeat (30) tick(1023);
    repeat (30) tick(100);
    check_int("t4 next period 9", last_period_high, 9);
    run_period(900, 9, "t4 mid glitch ignored");

    // 6: audio tone pattern, alternate 900/100 each period
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) run_period(100, 87, "t6 alternate high run");
      else            run_period(900, 9, "t6 alternate low run");
    end
    prev_d = 900;

    // Random duty words, one per period
    for (int i = 0; i < 15; i++) begin
      int d;
      d = int'($urandom_range(0, FS - 1));
      run_period(d, (prev_d * P) / FS, $sformatf("rand period %0d duty %0d", i, d));
      prev_d = d;
    end

    // 5: asynchronous reset at counter 30 while high
    run_period(900, (prev_d * P) / FS, "t5 setup period");
    repeat (30) tick(900);
    check_bit("t5 high before reset", bus.signal, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_bit("t5 async fall", bus.signal, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check_bit("t5 low during reset", bus.signal, 1'b0);
    #1;
    reset = 1'b0;
    model_reset();
    run_period(900, 0, "t5 first period after reset low");
    run_period(900, 87, "t5 second period after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
